// File: rtl/supply_rail_sequencer.sv
// Multi-rail supply sequencer: ramps rails up in ascending order and down in
// descending order, one fixed step per cycle, with a settle hold between rails.
module supply_rail_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int VOLT_W     = 32,
    parameter int STEP_UV    = 50000,
    parameter int SETTLE_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_on,
    input  logic [NUM_CH*VOLT_W-1:0] target_uv,
    input  logic                     kill,
    output logic [NUM_CH*VOLT_W-1:0] ch_uv,
    output logic [NUM_CH*2-1:0]      ch_state,
    output logic                     busy,
    output logic                     done,
    output logic                     fault
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [IDX_W-1:0]  IDX_FIRST = '0;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VOLT_W:0]   STEP_EXT  = (VOLT_W + 1)'(STEP_UV);

    // Encoding shared with the UPF supply-net model
    localparam logic [1:0] ST_OFF     = 2'b00;
    localparam logic [1:0] ST_ON      = 2'b01;
    localparam logic [1:0] ST_PARTIAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        SETTLE,
        DONE
    } fsm_t;

    fsm_t              state_q;
    logic [VOLT_W-1:0] uv_q     [NUM_CH];
    logic [VOLT_W-1:0] goal_q   [NUM_CH];
    logic [VOLT_W-1:0] on_tgt_q [NUM_CH];
    logic [IDX_W-1:0]  idx_q;
    logic              up_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [VOLT_W-1:0] cur_v;
    logic [VOLT_W-1:0] cur_g;
    logic [VOLT_W-1:0] nxt_v;

    // One step upward in VOLT_W+1 bits, clamped at the goal so it never wraps.
    function automatic logic [VOLT_W-1:0] sat_up(input logic [VOLT_W-1:0] v,
                                                  input logic [VOLT_W-1:0] g);
        logic [VOLT_W:0] sum;
        sum = {1'b0, v} + STEP_EXT;
        return (sum >= {1'b0, g}) ? g : sum[VOLT_W-1:0];
    endfunction

    // One step downward, floored at zero and then at the goal.
    function automatic logic [VOLT_W-1:0] sat_down(input logic [VOLT_W-1:0] v,
                                                    input logic [VOLT_W-1:0] g);
        logic [VOLT_W:0] diff;
        diff = ({1'b0, v} > STEP_EXT) ? ({1'b0, v} - STEP_EXT) : '0;
        return (diff <= {1'b0, g}) ? g : diff[VOLT_W-1:0];
    endfunction

    function automatic logic [1:0] decode_state(input logic [VOLT_W-1:0] v,
                                                input logic [VOLT_W-1:0] on_tgt);
        if (v == '0) begin
            return ST_OFF;
        end else if (v >= on_tgt) begin
            return ST_ON;
        end
        return ST_PARTIAL;
    endfunction

    always_comb begin
        cur_v = uv_q[idx_q];
        cur_g = goal_q[idx_q];
        if (cur_v < cur_g) begin
            nxt_v = sat_up(cur_v, cur_g);
        end else if (cur_v > cur_g) begin
            nxt_v = sat_down(cur_v, cur_g);
        end else begin
            nxt_v = cur_v;
        end
    end

    always_comb begin
        ch_uv    = '0;
        ch_state = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_uv[i*VOLT_W +: VOLT_W] = uv_q[i];
            ch_state[2*i +: 2]        = decode_state(uv_q[i], on_tgt_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                uv_q[i]     <= '0;
                goal_q[i]   <= '0;
                on_tgt_q[i] <= '0;
            end
            idx_q     <= '0;
            up_q      <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            cmd_ready <= 1'b1;
        end else if (kill) begin
            // Emergency off wins over any command or sequence in flight
            for (int i = 0; i < NUM_CH; i++) begin
                uv_q[i] <= '0;
            end
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b1;
            cmd_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            goal_q[i] <= cmd_on ? target_uv[i*VOLT_W +: VOLT_W] : '0;
                            if (cmd_on) begin
                                on_tgt_q[i] <= target_uv[i*VOLT_W +: VOLT_W];
                            end
                        end
                        up_q      <= cmd_on;
                        idx_q     <= cmd_on ? IDX_FIRST : IDX_LAST;
                        fault     <= 1'b0;
                        state_q   <= RAMP;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                RAMP: begin
                    uv_q[idx_q] <= nxt_v;
                    if (nxt_v == cur_g) begin
                        state_q <= SETTLE;
                        cnt_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        if (up_q ? (idx_q == IDX_LAST) : (idx_q == IDX_FIRST)) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            idx_q   <= up_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
                            state_q <= RAMP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_supply_rail_sequencer.sv
// Bench for supply_rail_sequencer: a trajectory model predicts every cycle,
// and directed sequences pin hand-computed voltages and cycle counts.
module tb_supply_rail_sequencer;

    localparam int NCH    = 2;
    localparam int VW     = 20;
    localparam int STEP   = 50000;
    localparam int SETTLE = 2;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_on    = 1'b0;
    logic [NCH*VW-1:0]   target_uv = '0;
    logic                kill      = 1'b0;
    logic                cmd_ready;
    logic [NCH*VW-1:0]   ch_uv;
    logic [NCH*2-1:0]    ch_state;
    logic                busy;
    logic                done;
    logic                fault;

    supply_rail_sequencer #(
        .NUM_CH    (NCH),
        .VOLT_W    (VW),
        .STEP_UV   (STEP),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_on   (cmd_on),
        .target_uv(target_uv),
        .kill     (kill),
        .ch_uv    (ch_uv),
        .ch_state (ch_state),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: expected outputs after each edge, planned as a whole at accept time
    longint            e_uv  [NCH];
    longint            m_on  [NCH];
    longint            m_goal[NCH];
    bit                e_busy  = 1'b0;
    bit                e_done  = 1'b0;
    bit                m_fault = 1'b0;
    logic [NCH*VW-1:0] q_uv[$];
    bit                q_dn[$];

    function automatic longint toward(input longint v, input longint g);
        longint d;
        if (v < g) return (v + STEP < g) ? v + STEP : g;
        if (v > g) begin
            d = v - STEP;
            if (d < 0) d = 0;
            return (d > g) ? d : g;
        end
        return v;
    endfunction

    function automatic logic [NCH*VW-1:0] pack(input longint v[NCH]);
        logic [NCH*VW-1:0] p;
        p = '0;
        for (int i = 0; i < NCH; i++) p[i*VW +: VW] = VW'(v[i]);
        return p;
    endfunction

    function automatic void plan_sequence(input bit up);
        longint v[NCH];
        for (int i = 0; i < NCH; i++) v[i] = e_uv[i];
        q_uv.push_back(pack(v));
        q_dn.push_back(1'b0);
        for (int k = 0; k < NCH; k++) begin
            int r;
            r = up ? k : NCH - 1 - k;
            do begin
                v[r] = toward(v[r], m_goal[r]);
                q_uv.push_back(pack(v));
                q_dn.push_back(1'b0);
            end while (v[r] != m_goal[r]);
            for (int s = 0; s < SETTLE; s++) begin
                q_uv.push_back(pack(v));
                q_dn.push_back(1'b0);
            end
        end
        q_dn[q_dn.size()-1] = 1'b1;
    endfunction

    function automatic void pop_plan();
        logic [NCH*VW-1:0] p;
        p = q_uv.pop_front();
        for (int i = 0; i < NCH; i++) e_uv[i] = longint'(p[i*VW +: VW]);
        e_done = q_dn.pop_front();
        e_busy = 1'b1;
    endfunction

    function automatic logic [1:0] exp_state(input longint v, input longint on);
        if (v == 0) return 2'b00;
        if (v >= on) return 2'b01;
        return 2'b11;
    endfunction

    initial begin
        for (int i = 0; i < NCH; i++) begin
            e_uv[i] = 0; m_on[i] = 0; m_goal[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NCH; i++) begin
                    e_uv[i] = 0; m_on[i] = 0; m_goal[i] = 0;
                end
                e_busy = 0; e_done = 0; m_fault = 0;
                q_uv.delete(); q_dn.delete();
            end else if (kill) begin
                for (int i = 0; i < NCH; i++) e_uv[i] = 0;
                e_busy = 0; e_done = 0; m_fault = 1;
                q_uv.delete(); q_dn.delete();
            end else if (q_dn.size() > 0) begin
                pop_plan();
            end else if (e_busy) begin
                e_busy = 0; e_done = 0;
            end else if (cmd_valid) begin
                for (int i = 0; i < NCH; i++) begin
                    m_goal[i] = cmd_on ? longint'(target_uv[i*VW +: VW]) : 0;
                    if (cmd_on) m_on[i] = longint'(target_uv[i*VW +: VW]);
                end
                m_fault = 0;
                plan_sequence(cmd_on);
                pop_plan();
            end
        end
    end

    initial begin
        logic [NCH*VW-1:0] exp_uv;
        logic [NCH*2-1:0]  exp_st;
        forever begin
            @(negedge clk);
            exp_uv = '0;
            exp_st = '0;
            for (int i = 0; i < NCH; i++) begin
                exp_uv[i*VW +: VW] = VW'(e_uv[i]);
                exp_st[2*i +: 2]   = exp_state(e_uv[i], m_on[i]);
            end
            check("cycle_ch_uv", 64'(ch_uv), 64'(exp_uv));
            check("cycle_ch_state", 64'(ch_state), 64'(exp_st));
            check("cycle_busy_ready_done_fault", 64'({busy, cmd_ready, done, fault}),
                  64'({e_busy, ~e_busy, e_done, m_fault}));
        end
    end

    logic [VW-1:0] tr0[64];
    logic [VW-1:0] tr1[64];
    logic [1:0]    st1[64];
    logic          b_tr[64];
    logic          r_tr[64];
    logic          d_tr[64];
    int            done_at;

    // Entered at a negedge with the DUT idle; cycle n is the n-th negedge after accept.
    task automatic run_cmd(input bit on, input logic [VW-1:0] t0, input logic [VW-1:0] t1,
                           input int kill_at, input int limit);
        cmd_valid = 1'b1;
        cmd_on    = on;
        target_uv = {t1, t0};
        done_at   = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            tr0[n] = ch_uv[VW-1:0];
            tr1[n] = ch_uv[2*VW-1:VW];
            st1[n] = ch_state[3:2];
            if (done === 1'b1 && done_at < 0) done_at = n;
            kill = (n == kill_at);
        end
        kill = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_ch_uv", 64'(ch_uv), 64'(0));
        check("reset_ch_state", 64'(ch_state), 64'(0));
        check("reset_ctrl", 64'({busy, cmd_ready, done, fault}), 64'(4'b0100));
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(1'b1, 20'd100000, 20'd60000, 0, 12);
        check("up_done_at", 64'(done_at), 64'(9));
        check("up_ch0_c2", 64'(tr0[2]), 64'(50000));
        check("up_ch0_c3", 64'(tr0[3]), 64'(100000));
        check("up_ch1_c5", 64'(tr1[5]), 64'(0));
        check("up_ch1_c6", 64'(tr1[6]), 64'(50000));
        check("up_ch1_state_c6", 64'(st1[6]), 64'(2'b11));
        check("up_ch1_c7", 64'(tr1[7]), 64'(60000));
        check("up_ch1_state_c7", 64'(st1[7]), 64'(2'b01));

        run_cmd(1'b0, 20'd12345, 20'd54321, 0, 12);
        check("down_done_at", 64'(done_at), 64'(9));
        check("down_ch1_c2", 64'(tr1[2]), 64'(10000));
        check("down_ch1_c3", 64'(tr1[3]), 64'(0));
        check("down_ch0_c3", 64'(tr0[3]), 64'(100000));
        check("down_ch0_c6", 64'(tr0[6]), 64'(50000));
        check("down_ch0_c7", 64'(tr0[7]), 64'(0));
        check("down_all_off", 64'(ch_state), 64'(0));

        run_cmd(1'b1, 20'hFFFF0, 20'd0, 0, 32);
        check("sat_done_at", 64'(done_at), 64'(27));
        check("sat_ch0_c21", 64'(tr0[21]), 64'(1000000));
        check("sat_ch0_c22", 64'(tr0[22]), 64'(20'hFFFF0));
        check("sat_ch0_final", 64'(ch_uv[VW-1:0]), 64'(20'hFFFF0));
        check("sat_states", 64'(ch_state), 64'(4'b0001));

        run_cmd(1'b1, 20'd100000, 20'd60000, 23, 30);
        check("kill_ch0_c20", 64'(tr0[20]), 64'(100000));
        check("kill_ch1_c23", 64'(tr1[23]), 64'(50000));
        check("kill_ch1_state_c23", 64'(st1[23]), 64'(2'b11));
        check("kill_ch0_c24", 64'(tr0[24]), 64'(0));
        check("kill_ch1_c24", 64'(tr1[24]), 64'(0));
        check("kill_no_done", 64'(done_at), 64'(-1));
        check("kill_fault", 64'({busy, fault}), 64'(2'b01));

        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        target_uv = {20'd60000, 20'd100000};
        kill      = 1'b1;
        @(negedge clk);
        check("kill_blocks_accept", 64'({busy, fault}), 64'(2'b01));
        kill = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_clears_fault", 64'({busy, fault}), 64'(2'b10));
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("retry_done_at", 64'(n), 64'(9));
        @(negedge clk);

        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        target_uv = {20'd60000, 20'd200000};
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            b_tr[c] = busy;
            r_tr[c] = cmd_ready;
            d_tr[c] = done;
            if (c == 1) cmd_on = 1'b0;
            if (c == 10) cmd_valid = 1'b0;
        end
        check("held_first_done", 64'(d_tr[8]), 64'(1));
        check("held_ready_c8", 64'(r_tr[8]), 64'(0));
        check("held_idle_c9", 64'({b_tr[9], r_tr[9]}), 64'(2'b01));
        check("held_accept_c10", 64'({b_tr[10], r_tr[10]}), 64'(2'b10));
        check("held_second_done", 64'(d_tr[20]), 64'(1));
        check("held_final_off", 64'(ch_uv), 64'(0));

        cmd_valid = 1'b1;
        cmd_on    = 1'b1;
        target_uv = {20'd60000, 20'd100000};
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("settle_pre_reset", 64'({busy, ch_uv[VW-1:0]}), 64'({1'b1, 20'd100000}));
        #1 rst_n = 1'b0;
        #1;
        check("async_ch_uv", 64'(ch_uv), 64'(0));
        check("async_ch_state", 64'(ch_state), 64'(0));
        check("async_ctrl", 64'({busy, cmd_ready, done, fault}), 64'(4'b0100));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
